// File: rtl/piso_sequencer_if.sv
// Handshake bundle for piso_sequencer: parallel-load side and serial-output side.
interface piso_sequencer_if #(
  parameter int N = 8
);
  localparam int SW = $clog2(N);

  logic          load_valid;
  logic [N-1:0]  load_data;
  logic          load_ready;
  logic          out_ready;
  logic          out_valid;
  logic          y;
  logic [SW-1:0] ss;
  logic          last;

  modport master (
    output load_valid, load_data, out_ready,
    input  load_ready, out_valid, y, ss, last
  );

  modport slave (
    input  load_valid, load_data, out_ready,
    output load_ready, out_valid, y, ss, last
  );
endinterface

// File: rtl/piso_sequencer.sv
// Parallel-in serial-out sequencer: holds one word and walks a mux select over it,
// one bit per output handshake, with a back-to-back reload on the final bit.
module piso_sequencer #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  piso_sequencer_if.slave  bus
);
  localparam int SW = $clog2(N);
  localparam logic [SW-1:0] FIRST_SS = MSB_FIRST ? SW'(N - 1) : '0;
  localparam logic [SW-1:0] LAST_SS  = MSB_FIRST ? '0 : SW'(N - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  word_q, word_d;
  logic [SW-1:0] ss_q, ss_d;

  logic out_valid;
  logic last;
  logic out_hs;
  logic load_ready;

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    ss_d       = ss_q;
    out_valid  = (state_q == SHIFT);
    last       = out_valid && (ss_q == LAST_SS);
    out_hs     = out_valid && bus.out_ready;
    load_ready = !out_valid || (out_hs && last);

    if (out_hs) begin
      if (last) begin
        state_d = IDLE;
      end else begin
        ss_d = MSB_FIRST ? ss_q - SW'(1) : ss_q + SW'(1);
      end
    end

    // A load in the last-bit cycle overrides the return to IDLE.
    if (bus.load_valid && load_ready) begin
      word_d  = bus.load_data;
      ss_d    = FIRST_SS;
      state_d = SHIFT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      ss_q    <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      ss_q    <= ss_d;
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.out_valid  = out_valid;
  assign bus.last       = last;
  assign bus.ss         = ss_q;
  assign bus.y          = word_q[ss_q];
endmodule

// File: tb/tb_piso_sequencer.sv
// Bench for piso_sequencer: LSB-first and MSB-first instances driven in lockstep,
// checked each cycle against a word/bit-position reference model.
module tb_piso_sequencer;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         lv;
  logic [N-1:0] ld;
  logic         ordy;

  always #5 clk = ~clk;

  piso_sequencer_if #(.N(N)) if_l ();
  piso_sequencer_if #(.N(N)) if_m ();

  assign if_l.load_valid = lv;
  assign if_l.load_data  = ld;
  assign if_l.out_ready  = ordy;
  assign if_m.load_valid = lv;
  assign if_m.load_data  = ld;
  assign if_m.out_ready  = ordy;

  piso_sequencer #(.N(N), .MSB_FIRST(1'b0)) dut_lsb (
    .clk   (clk),
    .reset (rst),
    .bus   (if_l.slave)
  );

  piso_sequencer #(.N(N), .MSB_FIRST(1'b1)) dut_msb (
    .clk   (clk),
    .reset (rst),
    .bus   (if_m.slave)
  );

  logic       ov  [2];
  logic       lr  [2];
  logic       lst [2];
  logic       yv  [2];
  logic [2:0] ssv [2];

  assign ov[0]  = if_l.out_valid;
  assign ov[1]  = if_m.out_valid;
  assign lr[0]  = if_l.load_ready;
  assign lr[1]  = if_m.load_ready;
  assign lst[0] = if_l.last;
  assign lst[1] = if_m.last;
  assign yv[0]  = if_l.y;
  assign yv[1]  = if_m.y;
  assign ssv[0] = if_l.ss;
  assign ssv[1] = if_m.ss;

  // Reference model: is a word in flight, which word, how many bits already sent.
  bit          m_busy  [2];
  logic [7:0]  m_word  [2];
  int unsigned m_k     [2];
  bit          m_clean [2];
  logic [7:0]  rx      [2];
  logic [7:0]  rx_done [2];

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d]  = 1'b0;
      m_word[d]  = '0;
      m_k[d]     = 0;
      m_clean[d] = 1'b1;
      rx[d]      = '0;
    end
  endtask

  task automatic cycle();
    logic [2:0] es;
    bit         elast;
    bit         elr;
    #2;
    for (int d = 0; d < 2; d++) begin
      es    = (d == 1) ? 3'(N - 1 - m_k[d]) : 3'(m_k[d]);
      elast = m_busy[d] && (m_k[d] == N - 1);
      elr   = !m_busy[d] || (ordy && elast);
      chk($sformatf("out_valid[%0d]", d), 32'(ov[d]), 32'(m_busy[d]));
      chk($sformatf("load_ready[%0d]", d), 32'(lr[d]), 32'(elr));
      chk($sformatf("last[%0d]", d), 32'(lst[d]), 32'(elast));
      if (m_busy[d]) begin
        chk($sformatf("ss[%0d]", d), 32'(ssv[d]), 32'(es));
        chk($sformatf("y[%0d]", d), 32'(yv[d]), 32'(m_word[d][es]));
      end else if (m_clean[d]) begin
        chk($sformatf("rst_ss[%0d]", d), 32'(ssv[d]), 32'd0);
        chk($sformatf("rst_y[%0d]", d), 32'(yv[d]), 32'd0);
      end
    end

    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_busy[d]  = 1'b0;
        m_word[d]  = '0;
        m_k[d]     = 0;
        m_clean[d] = 1'b1;
        rx[d]      = '0;
      end else begin
        elast = m_busy[d] && (m_k[d] == N - 1);
        elr   = !m_busy[d] || (ordy && elast);
        if (m_busy[d] && ordy) begin
          rx[d] = (d == 1) ? {rx[d][6:0], yv[d]} : {yv[d], rx[d][7:1]};
          if (elast) begin
            chk($sformatf("word_rebuilt[%0d]", d), 32'(rx[d]), 32'(m_word[d]));
            rx_done[d] = rx[d];
            m_busy[d]  = 1'b0;
          end else begin
            m_k[d]++;
          end
        end
        if (lv && elr) begin
          m_busy[d]  = 1'b1;
          m_word[d]  = ld;
          m_k[d]     = 0;
          m_clean[d] = 1'b0;
          rx[d]      = '0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] w);
    lv = 1'b1;
    ld = w;
    cycle();
    lv = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    lv   = 1'b0;
    ld   = '0;
    ordy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    lv = 1'b1;
    ordy = 1'b1;
    cycle();
    lv = 1'b0;
    rst = 1'b0;
    cycle();

    // Basic serialisation, both bit orders.
    ordy = 1'b1;
    load_word(8'b10101100);
    repeat (N) cycle();
    chk("basic_lsb_word", 32'(rx_done[0]), 32'h000000AC);
    chk("basic_msb_word", 32'(rx_done[1]), 32'h000000AC);
    repeat (2) cycle();

    // Backpressure at ss=3 (LSB instance).
    load_word(8'b10101100);
    repeat (3) cycle();
    ordy = 1'b0;
    repeat (5) cycle();
    chk("bp_ss", 32'(ssv[0]), 32'd3);
    chk("bp_y", 32'(yv[0]), 32'd1);
    ordy = 1'b1;
    repeat (N - 3) cycle();
    chk("bp_word", 32'(rx_done[0]), 32'h000000AC);
    cycle();

    // Back-to-back: 8'h00 held on load_valid while 8'hFF is shifting.
    load_word(8'hFF);
    lv = 1'b1;
    ld = 8'h00;
    repeat (N) cycle();
    lv = 1'b0;
    chk("b2b_valid", 32'(ov[0]), 32'd1);
    chk("b2b_ss", 32'(ssv[0]), 32'd0);
    chk("b2b_y", 32'(yv[0]), 32'd0);
    repeat (N + 1) cycle();

    // Ignored load pulse at ss=2.
    load_word(8'hFF);
    repeat (2) cycle();
    lv = 1'b1;
    ld = 8'h00;
    cycle();
    lv = 1'b0;
    repeat (N - 3) cycle();
    chk("ign_word", 32'(rx_done[0]), 32'h000000FF);
    cycle();

    // Mid-word reset at ss=4.
    load_word(8'h5A);
    repeat (4) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (4) cycle();

    // Randomised traffic including reset collisions.
    for (int i = 0; i < 3000; i++) begin
      lv   = 1'($urandom_range(0, 1));
      ld   = 8'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      rst  = ($urandom_range(0, 63) == 0);
      cycle();
    end
    rst  = 1'b0;
    lv   = 1'b0;
    ordy = 1'b1;
    repeat (N + 2) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/piso_sequencer.md
PISO_SEQUENCER -- requirements
Module: piso_sequencer

Interface
REQ-001 SHALL have parameter N, default 8: word width and number of select positions; N >= 2, power of two.
REQ-002 SHALL have parameter MSB_FIRST, default 0: 0 = emit bit 0 first, 1 = emit bit N-1 first.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port load_valid, input, 1 bit: upstream offers a parallel word.
REQ-006 SHALL have port load_data, input, N bits: parallel word to serialise.
REQ-007 SHALL have port load_ready, output, 1 bit: block accepts load_data this cycle.
REQ-008 SHALL have port out_ready, input, 1 bit: downstream accepts the current serial bit.
REQ-009 SHALL have port out_valid, output, 1 bit: y and ss are valid.
REQ-010 SHALL have port y, output, 1 bit: current serial bit, equal to the held word indexed by ss.
REQ-011 SHALL have port ss, output, $clog2(N) bits: current select index, usable directly as the select input of an N-to-1 mux.
REQ-012 SHALL have port last, output, 1 bit: current bit is the final bit of the word.

Function
REQ-013 SHALL implement a two-state FSM, IDLE and SHIFT, plus an N-bit word register and a $clog2(N)-bit select counter.
REQ-014 In IDLE, SHALL drive load_ready=1, out_valid=0 and last=0.
REQ-015 A load handshake (load_valid && load_ready) SHALL capture load_data into the word register, set ss to 0 (MSB_FIRST=0) or N-1 (MSB_FIRST=1), and enter SHIFT at the next edge.
REQ-016 The first bit SHALL appear with out_valid=1 in the cycle after the load handshake (1-cycle latency).
REQ-017 In SHIFT, SHALL drive out_valid=1, and y SHALL equal word[ss] combinationally from registered state.
REQ-018 In SHIFT, last SHALL be 1 exactly when ss = N-1 (MSB_FIRST=0) or ss = 0 (MSB_FIRST=1).
REQ-019 An output handshake (out_valid && out_ready) with last=0 SHALL step ss by +1 (MSB_FIRST=0) or -1 (MSB_FIRST=1) at the next edge.
REQ-020 While out_valid=1 and out_ready=0, ss, y, last and the word register SHALL hold unchanged for any number of cycles.
REQ-021 An output handshake with last=1 SHALL return the FSM to IDLE, unless a load handshake occurs in the same cycle.
REQ-022 load_ready SHALL be 1 in IDLE, 1 in SHIFT when out_valid && out_ready && last, and 0 otherwise.
REQ-023 A load handshake in the same cycle as a last-bit output handshake SHALL capture the new word, reinitialise ss and remain in SHIFT, giving back-to-back words with no idle bubble.
REQ-024 load_valid while load_ready=0 SHALL be ignored, and the held word SHALL remain unaffected.
REQ-025 load_data changes without a load handshake SHALL NOT affect y.
REQ-026 The select counter SHALL never leave the range 0..N-1; no wrap past the end of a word is permitted.
REQ-027 Each accepted word SHALL produce exactly N output handshakes.

Reset
REQ-028 While reset=1 at a rising edge, the block SHALL enter IDLE, clear the word register to 0 and set ss to 0, giving out_valid=0, last=0, y=0 and load_ready=1 after that edge.
REQ-029 Reset SHALL take priority over all handshakes in the same cycle.
REQ-030 Reset asserted mid-word SHALL discard the remaining bits, and no further out_valid SHALL occur until a new load handshake.

Verification
REQ-031 The bench SHALL cover basic serialisation: N=8, MSB_FIRST=0, load 8'b10101100, out_ready=1 -> y over ss 0..7 is 0,0,1,1,0,1,0,1; last=1 only at ss=7; then IDLE.
REQ-032 The bench SHALL cover MSB-first order: MSB_FIRST=1, same word -> ss steps 7..0, y is 1,0,1,0,1,1,0,0, last at ss=0.
REQ-033 The bench SHALL cover backpressure: hold out_ready=0 for 5 cycles at ss=3 -> ss=3, y=1, out_valid=1 stay constant, then resume with no bit lost or repeated.
REQ-034 The bench SHALL cover back-to-back words: load 8'hFF, then offer 8'h00 with load_valid held high -> it is accepted in the ss=7 handshake cycle, and the next cycle shows ss=0, y=0, out_valid=1.
REQ-035 The bench SHALL cover an ignored load: pulse load_valid with 8'h00 while ss=2 of word 8'hFF -> load_ready=0 and the remaining bits are all 1.
REQ-036 The bench SHALL cover mid-word reset: assert reset at ss=4 -> next cycle out_valid=0, ss=0, load_ready=1; no further bits until a new load.
